// File: rtl/pipeline_pkg.sv
// Shared encodings for the RV32 pipeline control blocks: hazard FSM states,
// forwarding-mux selects and the result-source code that marks a load.
package pipeline_pkg;

    typedef enum logic [1:0] {
        INIT    = 2'd0,
        RUN     = 2'd1,
        MEMWAIT = 2'd2
    } hazState_t;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    localparam logic [1:0] RESULT_LOAD = 2'b01;

endpackage

// File: rtl/hazard_ctrl_fwd_sel.sv
// Forwarding select for one E-stage source operand. The M stage is preferred over W
// because it holds the younger result. x0 is never forwarded.
module fwd_sel
    import pipeline_pkg::*;
(
    input  logic       enable,
    input  logic [4:0] rsE,
    input  logic [4:0] rdM,
    input  logic       regWriteM,
    input  logic [4:0] rdW,
    input  logic       regWriteW,
    output logic [1:0] fwdSel
);

    always_comb begin
        fwdSel = FWD_RF;
        if (enable) begin
            if (regWriteM && (rdM != 5'd0) && (rdM == rsE))
                fwdSel = FWD_M;
            else if (regWriteW && (rdW != 5'd0) && (rdW == rsE))
                fwdSel = FWD_W;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage RV32 pipeline: drives stage
// stall/flush controls, E-stage forwarding selects, and stall/flush performance counters.
module hazard_ctrl
    import pipeline_pkg::*;
#(
    parameter int INIT_CYCLES = 4,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [4:0]       Rs1E,
    input  logic [4:0]       Rs2E,
    input  logic [4:0]       RdE,
    input  logic [4:0]       RdM,
    input  logic [4:0]       RdW,
    input  logic [1:0]       ResultSrcE,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic             PCSrcE,
    input  logic             DMemReq,
    input  logic             DMemReady,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushM,
    output logic             FlushW,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic [CNT_W-1:0] StallCount,
    output logic [CNT_W-1:0] FlushCount
);

    localparam logic [3:0]       INIT_LAST = 4'(INIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = 1;
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    hazState_t  state;
    hazState_t  stateNext;
    logic [3:0] initCnt;
    logic       loadUse;
    logic       branchFlush;
    logic       fwdEnable;

    assign loadUse   = (ResultSrcE == RESULT_LOAD) && (RdE != 5'd0) &&
                       ((RdE == Rs1D) || (RdE == Rs2D));
    assign fwdEnable = (state != INIT);

    fwd_sel fwdA (
        .enable    (fwdEnable),
        .rsE       (Rs1E),
        .rdM       (RdM),
        .regWriteM (RegWriteM),
        .rdW       (RdW),
        .regWriteW (RegWriteW),
        .fwdSel    (ForwardAE)
    );

    fwd_sel fwdB (
        .enable    (fwdEnable),
        .rsE       (Rs2E),
        .rdM       (RdM),
        .regWriteM (RegWriteM),
        .rdW       (RdW),
        .regWriteW (RegWriteW),
        .fwdSel    (ForwardBE)
    );

    always_comb begin
        stateNext   = state;
        StallF      = 1'b0;
        StallD      = 1'b0;
        StallE      = 1'b0;
        StallM      = 1'b0;
        FlushD      = 1'b0;
        FlushE      = 1'b0;
        FlushM      = 1'b0;
        FlushW      = 1'b0;
        branchFlush = 1'b0;

        // A memory stall freezes F..M and bubbles W; PCSrcE is ignored until E is released.
        if (state == INIT) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
            FlushM = 1'b1;
            FlushW = 1'b1;
            if (initCnt == INIT_LAST)
                stateNext = RUN;
        end else if ((state == MEMWAIT && !DMemReady) ||
                     (state == RUN && DMemReq && !DMemReady)) begin
            StallF    = 1'b1;
            StallD    = 1'b1;
            StallE    = 1'b1;
            StallM    = 1'b1;
            FlushW    = 1'b1;
            stateNext = MEMWAIT;
        end else begin
            stateNext = RUN;
            if (PCSrcE) begin
                FlushD      = 1'b1;
                FlushE      = 1'b1;
                branchFlush = 1'b1;
            end else if (loadUse) begin
                StallF = 1'b1;
                StallD = 1'b1;
                FlushE = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= INIT;
            initCnt    <= 4'd0;
            StallCount <= '0;
            FlushCount <= '0;
        end else begin
            state <= stateNext;
            if (state == INIT && initCnt != INIT_LAST)
                initCnt <= initCnt + 4'd1;
            else
                initCnt <= 4'd0;
            if (StallF && StallCount != CNT_MAX)
                StallCount <= StallCount + CNT_ONE;
            if (branchFlush && FlushCount != CNT_MAX)
                FlushCount <= FlushCount + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed scenarios plus randomized traffic,
// checked against a cycle-level behavioural model of the pipeline control rules.
module tb_hazard_ctrl;

    localparam int INIT_CYC = 4;
    localparam int CNT_W    = 6;
    localparam int CNT_SAT  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset;
    logic [4:0]       Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic [1:0]       ResultSrcE;
    logic             RegWriteM, RegWriteW, PCSrcE, DMemReq, DMemReady;
    logic             StallF, StallD, StallE, StallM;
    logic             FlushD, FlushE, FlushM, FlushW;
    logic [1:0]       ForwardAE, ForwardBE;
    logic [CNT_W-1:0] StallCount, FlushCount;

    hazard_ctrl #(.INIT_CYCLES(INIT_CYC), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
        .RdM(RdM), .RdW(RdW), .ResultSrcE(ResultSrcE),
        .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .PCSrcE(PCSrcE),
        .DMemReq(DMemReq), .DMemReady(DMemReady),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM), .FlushW(FlushW),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .StallCount(StallCount), .FlushCount(FlushCount)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        logic [3:0] stall;   // {F,D,E,M}
        logic [3:0] flush;   // {D,E,M,W}
        logic [1:0] fa;
        logic [1:0] fb;
        int         sc;
        int         fc;
    } exp_t;

    exp_t expQ[$];
    int   checks = 0;
    int   errors = 0;

    // Model state: clocks left in the post-reset fill, whether a data access is pending
    int initLeft = INIT_CYC;
    bit memPending = 1'b0;
    int stallCnt = 0;
    int flushCnt = 0;

    function automatic logic [1:0] refFwd(input logic [4:0] rs);
        if (RegWriteM && RdM != 0 && RdM == rs) return 2'b10;
        if (RegWriteW && RdW != 0 && RdW == rs) return 2'b01;
        return 2'b00;
    endfunction

    task automatic expectCycle(input string tag);
        exp_t e;
        bit   ldUse;
        e.tag = tag; e.stall = 4'b0000; e.flush = 4'b0000; e.fa = 2'b00; e.fb = 2'b00;
        if (!reset) begin
            initLeft = INIT_CYC; memPending = 1'b0; stallCnt = 0; flushCnt = 0;
            e.flush = 4'b1111;
        end else if (initLeft > 0) begin
            e.flush = 4'b1111;
            initLeft--;
        end else begin
            e.fa = refFwd(Rs1E);
            e.fb = refFwd(Rs2E);
        end
        e.sc = stallCnt;
        e.fc = flushCnt;
        if (reset && e.flush != 4'b1111) begin
            ldUse = (ResultSrcE == 2'b01) && RdE != 0 && (RdE == Rs1D || RdE == Rs2D);
            if ((memPending || DMemReq) && !DMemReady) begin
                e.stall = 4'b1111; e.flush = 4'b0001; memPending = 1'b1;
            end else begin
                memPending = 1'b0;
                if (PCSrcE) begin
                    e.flush = 4'b1100;
                    if (flushCnt < CNT_SAT) flushCnt++;
                end else if (ldUse) begin
                    e.stall = 4'b1100; e.flush = 4'b0100;
                end
            end
            if (e.stall[3] && stallCnt < CNT_SAT) stallCnt++;
        end
        expQ.push_back(e);
    endtask

    always @(negedge clk) begin
        if (expQ.size() > 0) begin
            exp_t e;
            e = expQ.pop_front();
            checks++;
            if ({StallF, StallD, StallE, StallM} !== e.stall ||
                {FlushD, FlushE, FlushM, FlushW} !== e.flush ||
                ForwardAE !== e.fa || ForwardBE !== e.fb ||
                int'(StallCount) != e.sc || int'(FlushCount) != e.fc) begin
                errors++;
                $display("FAIL %s: got stall=%b flush=%b fwdA=%b fwdB=%b sc=%0d fc=%0d; want stall=%b flush=%b fwdA=%b fwdB=%b sc=%0d fc=%0d",
                         e.tag, {StallF, StallD, StallE, StallM}, {FlushD, FlushE, FlushM, FlushW},
                         ForwardAE, ForwardBE, StallCount, FlushCount,
                         e.stall, e.flush, e.fa, e.fb, e.sc, e.fc);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        Rs1D = 5'd0; Rs2D = 5'd0; Rs1E = 5'd0; Rs2E = 5'd0;
        RdE = 5'd0; RdM = 5'd0; RdW = 5'd0; ResultSrcE = 2'b00;
        RegWriteM = 1'b0; RegWriteW = 1'b0; PCSrcE = 1'b0;
        DMemReq = 1'b0; DMemReady = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        idle();

        // Reset, then post-reset fill
        tick(); expectCycle("resetHold");
        tick(); reset = 1'b1; expectCycle("init1");
        for (int i = 2; i <= INIT_CYC; i++) begin
            tick(); expectCycle($sformatf("init%0d", i));
        end
        tick(); expectCycle("firstRun");

        // Load-use bubble, then load has moved to M
        tick(); ResultSrcE = 2'b01; RdE = 5'd5; Rs1D = 5'd5; expectCycle("loadUse");
        tick(); idle(); RdM = 5'd5; expectCycle("loadUseClear");

        // Forwarding priority
        tick(); idle(); RdM = 5'd3; RegWriteM = 1'b1; RdW = 5'd3; RegWriteW = 1'b1;
        Rs1E = 5'd3; Rs2E = 5'd3; expectCycle("fwdM");
        tick(); RegWriteM = 1'b0; expectCycle("fwdW");
        tick(); RegWriteM = 1'b1; RdM = 5'd0; RdW = 5'd0; Rs1E = 5'd0; Rs2E = 5'd0;
        expectCycle("fwdX0");

        // Taken branch alongside load-use: flush only
        tick(); idle(); PCSrcE = 1'b1; ResultSrcE = 2'b01; RdE = 5'd7; Rs2D = 5'd7;
        expectCycle("branchOverLoad");
        tick(); idle(); ResultSrcE = 2'b01; RdE = 5'd0; Rs1D = 5'd0; expectCycle("loadX0");

        // Data memory wait
        tick(); idle(); DMemReq = 1'b1; expectCycle("memWait1");
        tick(); PCSrcE = 1'b1; expectCycle("memWait2");
        tick(); PCSrcE = 1'b0; expectCycle("memWait3");
        tick(); DMemReady = 1'b1; expectCycle("memDone");
        tick(); idle(); expectCycle("afterMem");

        // Reset asserted during a memory wait
        tick(); DMemReq = 1'b1; expectCycle("memWaitPreRst");
        tick(); expectCycle("memWaitPreRst2");
        tick(); reset = 1'b0; expectCycle("asyncReset");
        tick(); idle(); reset = 1'b1; expectCycle("reinit1");
        for (int i = 2; i <= INIT_CYC; i++) begin
            tick(); expectCycle($sformatf("reinit%0d", i));
        end
        tick(); expectCycle("rerun");

        // Randomized traffic with a narrow register range to provoke collisions
        for (int n = 0; n < 1500; n++) begin
            tick();
            reset      = ($urandom_range(0, 149) != 0);
            Rs1D       = 5'($urandom_range(0, 3));
            Rs2D       = 5'($urandom_range(0, 3));
            Rs1E       = 5'($urandom_range(0, 3));
            Rs2E       = 5'($urandom_range(0, 3));
            RdE        = 5'($urandom_range(0, 3));
            RdM        = 5'($urandom_range(0, 3));
            RdW        = 5'($urandom_range(0, 3));
            ResultSrcE = 2'($urandom_range(0, 3));
            RegWriteM  = 1'($urandom_range(0, 1));
            RegWriteW  = 1'($urandom_range(0, 1));
            PCSrcE     = ($urandom_range(0, 5) == 0);
            DMemReq    = ($urandom_range(0, 2) == 0);
            DMemReady  = ($urandom_range(0, 1) == 0);
            expectCycle("random");
        end

        tick(); idle();
        for (int w = 0; w < 10 && expQ.size() > 0; w++) @(negedge clk);
        #1;
        if (expQ.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d expected responses left unchecked, want 0", expQ.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
